// File: rtl/nspi_pkg.sv
// Shared types and helpers for the N-channel SPI transmitter.
// Holds the FSM state encoding and counter sizing.
package nspi_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOW,
    HIGH,
    FINISH
  } state_e;

  // Counter width for a range of n values, never narrower than 1 bit.
  function automatic int cnt_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/nspi_shift_lane.sv
// One MOSI lane: captures a word, then presents it bit by bit.
// The serial bit is registered so the lane output is glitch free.
module nspi_shift_lane
  import nspi_pkg::*;
#(
  parameter int SPI_SIZE  = 8,
  parameter int MSB_FIRST = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                load_i,
  input  logic                shift_i,
  input  logic                clr_i,
  input  logic [SPI_SIZE-1:0] data_i,
  output logic                mosi_o
);

  logic [SPI_SIZE-1:0] sr_q;
  logic [SPI_SIZE-1:0] sr_d;
  logic                mosi_q;

  // Word after one shift towards the output end.
  always_comb begin
    sr_d = sr_q;
    if (MSB_FIRST != 0) sr_d = sr_q << 1;
    else                sr_d = sr_q >> 1;
  end

  // Load, shift or clear the word and its output bit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sr_q   <= '0;
      mosi_q <= 1'b0;
    end else if (load_i) begin
      sr_q   <= data_i;
      mosi_q <= (MSB_FIRST != 0) ? data_i[SPI_SIZE-1]
                                 : data_i[0];
    end else if (shift_i) begin
      sr_q   <= sr_d;
      mosi_q <= (MSB_FIRST != 0) ? sr_d[SPI_SIZE-1]
                                 : sr_d[0];
    end else if (clr_i) begin
      mosi_q <= 1'b0;
    end
  end

  assign mosi_o = mosi_q;

endmodule

// File: rtl/nspi_tx.sv
// N-channel parallel SPI transmitter, mode 0, TX only.
// All lanes share spi_clk and bit timing; data is per lane.
module nspi_tx
  import nspi_pkg::*;
#(
  parameter int CHANNEL_NUMBER = 2,
  parameter int SPI_SIZE       = 8,
  parameter int MSB_FIRST      = 1,
  parameter int CLK_HALF       = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start_tx,
  output logic                      tx_finish,
  input  logic [SPI_SIZE-1:0]       data_in [CHANNEL_NUMBER],
  output logic                      spi_clk,
  output logic [CHANNEL_NUMBER-1:0] spi_mosi
);

  localparam int CW = cnt_w(SPI_SIZE);
  localparam int DW = cnt_w(CLK_HALF);

  localparam logic [CW-1:0] LAST_BIT = CW'(SPI_SIZE - 1);
  localparam logic [DW-1:0] DIV_END  = DW'(CLK_HALF - 1);

  state_e        state_q;
  logic [CW-1:0] bit_q;
  logic [DW-1:0] div_q;
  logic          sclk_q;
  logic          fin_q;

  logic half_done;
  logic last_bit;
  logic load;
  logic shift;
  logic clr;

  // Lane control decoded from the current state.
  always_comb begin
    half_done = (div_q == DIV_END);
    last_bit  = (bit_q == LAST_BIT);
    load      = (state_q == IDLE) && start_tx;
    shift     = (state_q == HIGH) && half_done && !last_bit;
    clr       = (state_q == HIGH) && half_done && last_bit;
  end

  // Sequencer: divider, bit counter, spi_clk and finish pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      bit_q   <= '0;
      div_q   <= '0;
      sclk_q  <= 1'b0;
      fin_q   <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          sclk_q <= 1'b0;
          fin_q  <= 1'b0;
          if (start_tx) begin
            bit_q   <= '0;
            div_q   <= '0;
            state_q <= LOW;
          end
        end
        LOW: begin
          if (half_done) begin
            div_q   <= '0;
            sclk_q  <= 1'b1;
            state_q <= HIGH;
          end else begin
            div_q <= div_q + DW'(1);
          end
        end
        HIGH: begin
          if (half_done) begin
            div_q  <= '0;
            sclk_q <= 1'b0;
            if (last_bit) begin
              fin_q   <= 1'b1;
              state_q <= FINISH;
            end else begin
              bit_q   <= bit_q + CW'(1);
              state_q <= LOW;
            end
          end else begin
            div_q <= div_q + DW'(1);
          end
        end
        FINISH: begin
          fin_q   <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  for (genvar c = 0; c < CHANNEL_NUMBER; c++) begin : g_lane
    nspi_shift_lane #(
      .SPI_SIZE (SPI_SIZE),
      .MSB_FIRST(MSB_FIRST)
    ) u_lane (
      .clk    (clk),
      .rst    (rst),
      .load_i (load),
      .shift_i(shift),
      .clr_i  (clr),
      .data_i (data_in[c]),
      .mosi_o (spi_mosi[c])
    );
  end

  assign spi_clk   = sclk_q;
  assign tx_finish = fin_q;

endmodule

// File: tb/tb_nspi_tx.sv
// Bench for nspi_tx: directed and random transfers on two
// configurations, checked cycle by cycle against a timing model.
module tb_nspi_tx;

  localparam int S  = 8;
  localparam int CH = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic          start_a = 1'b0;
  logic          start_b = 1'b0;
  logic [S-1:0]  din_a [CH];
  logic [S-1:0]  din_b [CH];
  logic          sclk_a, sclk_b;
  logic          fin_a, fin_b;
  logic [CH-1:0] mosi_a, mosi_b;

  int vectors     = 0;
  int miscompares = 0;

  nspi_tx dut_a (
    .clk      (clk),
    .rst      (rst),
    .start_tx (start_a),
    .tx_finish(fin_a),
    .data_in  (din_a),
    .spi_clk  (sclk_a),
    .spi_mosi (mosi_a)
  );

  nspi_tx #(
    .CHANNEL_NUMBER(2),
    .SPI_SIZE      (8),
    .MSB_FIRST     (0),
    .CLK_HALF      (2)
  ) dut_b (
    .clk      (clk),
    .rst      (rst),
    .start_tx (start_b),
    .tx_finish(fin_b),
    .data_in  (din_b),
    .spi_clk  (sclk_b),
    .spi_mosi (mosi_b)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // {spi_clk, mosi[1:0], tx_finish} of the chosen instance.
  function automatic logic [3:0] outs(input bit b);
    return b ? {sclk_b, mosi_b, fin_b} : {sclk_a, mosi_a, fin_a};
  endfunction

  // Expected outputs n cycles after the start edge, from the
  // protocol rules: spi_clk toggles every h cycles starting low,
  // bit k occupies one full period, then one finish cycle.
  function automatic logic [3:0] model(input int msb, input int h,
                                       input logic [7:0] w0,
                                       input logic [7:0] w1,
                                       input int n);
    int total;
    int k;
    int idx;
    logic sc;
    total = 2 * S * h;
    if (n < total) begin
      sc  = ((n / h) % 2) == 1;
      k   = n / (2 * h);
      idx = (msb != 0) ? (S - 1 - k) : k;
      return {sc, w1[idx], w0[idx], 1'b0};
    end else if (n == total) begin
      return 4'b0001;
    end
    return 4'b0000;
  endfunction

  task automatic set_start(input bit b, input logic v);
    if (b) start_b = v;
    else   start_a = v;
  endtask

  task automatic idle_chk(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk); #1;
      chk("idle_a", {28'd0, outs(1'b0)}, 32'd0);
      chk("idle_b", {28'd0, outs(1'b1)}, 32'd0);
    end
  endtask

  // One transfer; poke re-asserts start mid-transfer, abort
  // pulls reset at that cycle. -1 disables either.
  task automatic run(input bit b,
                     input logic [7:0] w0, input logic [7:0] w1,
                     input int poke, input int abort);
    int h;
    int msb;
    int total;
    int pulses;
    int fins;
    logic prev;
    logic [3:0] o;
    h      = b ? 2 : 1;
    msb    = b ? 0 : 1;
    total  = 2 * S * h;
    pulses = 0;
    fins   = 0;
    prev   = 1'b0;
    @(negedge clk);
    if (b) begin din_b[0] = w0; din_b[1] = w1; end
    else   begin din_a[0] = w0; din_a[1] = w1; end
    set_start(b, 1'b1);
    for (int n = 0; n <= total + 1; n++) begin
      @(posedge clk); #1;
      if (n == 0) begin
        set_start(b, 1'b0);
        din_a[0] = 8'($urandom); din_a[1] = 8'($urandom);
        din_b[0] = 8'($urandom); din_b[1] = 8'($urandom);
      end
      if (n == poke + 1) set_start(b, 1'b0);
      o = outs(b);
      chk($sformatf("%s_w%02h%02h_n%0d", b ? "B" : "A", w1, w0, n),
          {28'd0, o}, {28'd0, model(msb, h, w0, w1, n)});
      if (o[3] && !prev) pulses++;
      prev = o[3];
      if (o[0]) fins++;
      if (n == poke) set_start(b, 1'b1);
      if (n == abort) begin
        rst = 1'b0;
        #1;
        chk("abort_now", {28'd0, outs(b)}, 32'd0);
        idle_chk(3);
        @(negedge clk);
        rst = 1'b1;
        idle_chk(3);
        return;
      end
    end
    chk("pulses", pulses, S);
    chk("fins", fins, 1);
  endtask

  initial begin
    din_a[0] = 8'h5A; din_a[1] = 8'hC3;
    din_b[0] = 8'h5A; din_b[1] = 8'hC3;
    start_a  = 1'b1;
    start_b  = 1'b1;
    idle_chk(4);
    @(negedge clk);
    start_a = 1'b0;
    start_b = 1'b0;
    rst     = 1'b1;
    idle_chk(2);

    run(1'b0, 8'h0F, 8'hF0, -1, -1);
    run(1'b0, 8'h0F, 8'hF0, -1, -1);
    run(1'b0, 8'hBB, 8'($urandom), -1, -1);
    run(1'b0, 8'h0F, 8'hF0, 6, -1);
    idle_chk(1);
    run(1'b0, 8'hA5, 8'h3C, -1, 8);
    run(1'b0, 8'h0F, 8'hF0, -1, -1);
    run(1'b1, 8'h01, 8'h80, -1, -1);
    run(1'b1, 8'h01, 8'h80, 9, -1);
    idle_chk(1);
    run(1'b1, 8'h96, 8'h69, -1, 13);

    for (int i = 0; i < 8; i++) begin
      run(1'($urandom), 8'($urandom), 8'($urandom), -1, -1);
      idle_chk(int'($urandom_range(0, 3)));
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
